sock_line_scheduler: RTL and testbench

- Round-robin scheduler that shares one knitting machine between NREQ sock-type order requesters.
- Grants the machine to one requester and sequences a fixed batch of socks, pacing each sock over KNIT_CYC cycles.
- Stalls while the yarn sensor is not ready, then issues a one-cycle package pulse and returns to arbitration.
- Sits above the per-type sock counters in the factory FSM and replaces their individual enable logic.

---
 rtl/sock_line_scheduler_if.sv | 36 +++
 rtl/sock_line_scheduler.sv | 178 +++++++++++++++++
 tb/tb_sock_line_scheduler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sock_line_scheduler_if.sv
// Order-line bundle between the sock-type requesters and the line scheduler.
//
// Handshake: each requester raises its REQ bit as a level and may hold it
// as long as it wants socks. The scheduler answers with a registered one-hot
// GNT held for the whole batch, then a one-cycle one-hot ACK together with
// PAC_V/PAC_ID when the package is complete. REQ is only sampled while the
// scheduler is idle, so a requester may drop or keep REQ at any time without
// affecting a batch that is already granted. PH and SR are plain levels.
interface sock_line_scheduler_if #(
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            PH;
  logic            SR;
  logic [NREQ-1:0] REQ;
  logic [NREQ-1:0] GNT;
  logic [2:0]      CNT;
  logic            PAC_V;
  logic [IDW-1:0]  PAC_ID;
  logic [NREQ-1:0] ACK;
  logic [2:0]      LED;
  logic            BUSY;

  // Requester/line side.
  modport master (
    output PH, SR, REQ,
    input  GNT, CNT, PAC_V, PAC_ID, ACK, LED, BUSY
  );

  // Scheduler side.
  modport slave (
    input  PH, SR, REQ,
    output GNT, CNT, PAC_V, PAC_ID, ACK, LED, BUSY
  );
endinterface

// File: rtl/sock_line_scheduler.sv
// Round-robin scheduler sharing one knitting machine between NREQ sock-type
// requesters. A granted requester gets a full batch of BATCH socks, each
// taking KNIT_CYC cycles; yarn-not-ready stalls, power loss aborts, and a
// finished batch ends with a single PACK cycle before re-arbitration.
module sock_line_scheduler #(
  parameter int NREQ     = 4,
  parameter int BATCH    = 7,
  parameter int KNIT_CYC = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  sock_line_scheduler_if.slave  bus,
  output logic [1:0]            o_state
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KNIT  = 2'd1,
    S_STALL = 2'd2,
    S_PACK  = 2'd3
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [2:0]      r_cnt;
  logic [3:0]      r_timer;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  r_ptr;

  state_t          w_state_nxt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [2:0]      w_cnt_nxt;
  logic [3:0]      w_timer_nxt;
  logic [IDW-1:0]  w_owner_nxt;
  logic [IDW-1:0]  w_ptr_nxt;
  logic            w_knit_go;
  logic            w_pick_vld;
  logic [IDW-1:0]  w_pick_idx;
  logic [2:0]      w_led;

  // (base + off) mod NREQ, with off < NREQ so one subtraction suffices.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first requesting index starting at the pointer.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_pick_vld && bus.REQ[wrap_add(r_ptr, k)]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = wrap_add(r_ptr, k);
      end
    end
  end

  // Next-state and next-register values for the batch sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_cnt_nxt   = r_cnt;
    w_timer_nxt = r_timer;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_knit_go   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.PH && w_pick_vld) begin
          w_owner_nxt = w_pick_idx;
          w_gnt_nxt   = onehot(w_pick_idx);
          w_cnt_nxt   = 3'd0;
          w_timer_nxt = 4'd0;
          w_state_nxt = S_KNIT;
        end
      end
      S_KNIT: begin
        if (!bus.PH) begin
          w_gnt_nxt   = '0;
          w_cnt_nxt   = 3'd0;
          w_timer_nxt = 4'd0;
          w_state_nxt = S_IDLE;
        end else if (!bus.SR) begin
          w_state_nxt = S_STALL;
        end else begin
          w_knit_go = 1'b1;
        end
      end
      S_STALL: begin
        if (!bus.PH) begin
          w_gnt_nxt   = '0;
          w_cnt_nxt   = 3'd0;
          w_timer_nxt = 4'd0;
          w_state_nxt = S_IDLE;
        end else if (bus.SR) begin
          // The resume cycle already knits, so an S-cycle yarn gap costs
          // exactly S cycles.
          w_state_nxt = S_KNIT;
          w_knit_go   = 1'b1;
        end
      end
      S_PACK: begin
        w_ptr_nxt   = wrap_add(r_owner, 1);
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // One knitting cycle: pace the sock, count it, finish the batch.
    if (w_knit_go) begin
      if (r_timer == 4'(KNIT_CYC - 1)) begin
        w_timer_nxt = 4'd0;
        w_cnt_nxt   = r_cnt + 3'd1;
        if (r_cnt == 3'(BATCH - 1)) begin
          w_state_nxt = S_PACK;
        end
      end else begin
        w_timer_nxt = r_timer + 4'd1;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_cnt   <= 3'd0;
      r_timer <= 4'd0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_timer <= w_timer_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Status LED decode from the registered state.
  always_comb begin
    w_led = 3'b000;
    case (r_state)
      S_KNIT:  w_led = 3'b001;
      S_STALL: w_led = 3'b010;
      S_PACK:  w_led = 3'b100;
      default: w_led = 3'b000;
    endcase
  end

  assign bus.GNT    = r_gnt;
  assign bus.CNT    = r_cnt;
  assign bus.PAC_V  = (r_state == S_PACK);
  assign bus.PAC_ID = (r_state == S_PACK) ? r_owner : '0;
  assign bus.ACK    = (r_state == S_PACK) ? onehot(r_owner) : '0;
  assign bus.LED    = w_led;
  assign bus.BUSY   = (r_state != S_IDLE);
  assign o_state    = r_state;

endmodule

// File: tb/tb_sock_line_scheduler.sv
// Bench for sock_line_scheduler: table of timed vectors for the single
// request batch, hand sequences for rotation, stall, abort and reset, and a
// package scoreboard fed with the expected packaged requester at grant time.
module tb_sock_line_scheduler;
  localparam int NREQ     = 4;
  localparam int BATCH    = 7;
  localparam int KNIT_CYC = 3;
  localparam int IDW      = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  sock_line_scheduler_if #(.NREQ(NREQ)) bus ();

  sock_line_scheduler #(
    .NREQ(NREQ), .BATCH(BATCH), .KNIT_CYC(KNIT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_state(dbg_state)
  );

  // Clock and counters.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [IDW-1:0] exp_q[$];
  logic [IDW-1:0] mon_id;

  typedef struct {
    logic            ph;
    logic            sr;
    logic [NREQ-1:0] req;
    int              n;
    logic [NREQ-1:0] gnt;
    logic [2:0]      cnt;
    logic            cnt_chk;
    logic [2:0]      led;
    logic            busy;
    logic            push;
    logic [IDW-1:0]  push_id;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic ph, input logic sr, input logic [NREQ-1:0] req,
                              input int n, input logic [NREQ-1:0] gnt, input logic [2:0] cnt,
                              input logic cnt_chk, input logic [2:0] led, input logic busy,
                              input logic push, input logic [IDW-1:0] push_id);
    vec_t v;
    v.ph = ph; v.sr = sr; v.req = req; v.n = n; v.gnt = gnt; v.cnt = cnt;
    v.cnt_chk = cnt_chk; v.led = led; v.busy = busy; v.push = push; v.push_id = push_id;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(bus.GNT),    32'd0);
    chk({tag, "_cnt"},    32'(bus.CNT),    32'd0);
    chk({tag, "_pacv"},   32'(bus.PAC_V),  32'd0);
    chk({tag, "_pacid"},  32'(bus.PAC_ID), 32'd0);
    chk({tag, "_ack"},    32'(bus.ACK),    32'd0);
    chk({tag, "_led"},    32'(bus.LED),    32'd0);
    chk({tag, "_busy"},   32'(bus.BUSY),   32'd0);
    chk({tag, "_state"},  32'(dbg_state),  32'd0);
  endtask

  // Package scoreboard: every PAC_V must match the oldest expected owner.
  always @(negedge clk) begin
    if (bus.PAC_V === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pac_unexpected: PAC_ID=%0d ACK=%0h expected no package", bus.PAC_ID, bus.ACK);
      end else begin
        mon_id = exp_q.pop_front();
        chk("pac_id",  32'(bus.PAC_ID), 32'(mon_id));
        chk("pac_ack", 32'(bus.ACK),    32'(1) << mon_id);
      end
    end else if (reset === 1'b0) begin
      chk("nopac_ack_id", 32'({bus.ACK, bus.PAC_ID}), 32'd0);
    end
  end

  initial begin
    int m_ptr;
    int exp_idx;
    int cyc;

    vecs[0] = mk(1, 1, 4'b0001,  1, 4'b0001, 3'd0, 1, 3'b001, 1, 1, 2'd0);
    vecs[1] = mk(1, 1, 4'b0001,  3, 4'b0001, 3'd1, 1, 3'b001, 1, 0, 2'd0);
    vecs[2] = mk(1, 1, 4'b0001,  3, 4'b0001, 3'd2, 1, 3'b001, 1, 0, 2'd0);
    vecs[3] = mk(1, 1, 4'b0001, 15, 4'b0001, 3'd7, 1, 3'b100, 1, 0, 2'd0);
    vecs[4] = mk(1, 1, 4'b0000,  1, 4'b0000, 3'd0, 0, 3'b000, 0, 0, 2'd0);
    vecs[5] = mk(0, 1, 4'b1111,  3, 4'b0000, 3'd0, 0, 3'b000, 0, 0, 2'd0);

    // Reset state.
    reset  = 1'b1;
    bus.PH = 1'b0;
    bus.SR = 1'b0;
    bus.REQ = '0;
    tick(2);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(1);

    // Single request batch and PH gating, from the vector table.
    for (int i = 0; i < 6; i++) begin
      bus.PH  = vecs[i].ph;
      bus.SR  = vecs[i].sr;
      bus.REQ = vecs[i].req;
      if (vecs[i].push) exp_q.push_back(vecs[i].push_id);
      tick(vecs[i].n);
      chk($sformatf("vec%0d_gnt", i), 32'(bus.GNT), 32'(vecs[i].gnt));
      if (vecs[i].cnt_chk) chk($sformatf("vec%0d_cnt", i), 32'(bus.CNT), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_led", i),  32'(bus.LED),  32'(vecs[i].led));
      chk($sformatf("vec%0d_busy", i), 32'(bus.BUSY), 32'(vecs[i].busy));
    end
    m_ptr = 1;

    // Round-robin with all requests held: grants rotate, 23 cycles apart.
    bus.PH  = 1'b1;
    bus.SR  = 1'b1;
    bus.REQ = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      exp_idx = m_ptr;
      exp_q.push_back(exp_idx[IDW-1:0]);
      tick(1);
      chk("rr_gnt", 32'(bus.GNT), 32'(1) << exp_idx);
      tick(BATCH * KNIT_CYC);
      chk("rr_pack_led", 32'(bus.LED), 32'b100);
      chk("rr_pack_gnt", 32'(bus.GNT), 32'(1) << exp_idx);
      if (b == 4) bus.REQ = '0;
      tick(1);
      chk("rr_idle_gnt", 32'(bus.GNT), 32'd0);
      chk("rr_idle_led", 32'(bus.LED), 32'd0);
      m_ptr = (exp_idx + 1) % NREQ;
    end

    // Stall of 5 cycles at CNT=3, with REQ dropped mid-batch.
    bus.REQ = 4'b0010;
    exp_q.push_back(2'd1);
    tick(1);
    chk("stall_gnt", 32'(bus.GNT), 32'b0010);
    bus.REQ = '0;
    tick(9);
    chk("stall_pre_cnt", 32'(bus.CNT), 32'd3);
    for (int i = 0; i < 5; i++) begin
      bus.SR = 1'b0;
      tick(1);
      chk("stall_led", 32'(bus.LED), 32'b010);
      chk("stall_cnt", 32'(bus.CNT), 32'd3);
      chk("stall_gnt_hold", 32'(bus.GNT), 32'b0010);
    end
    bus.SR = 1'b1;
    cyc = 0;
    while (bus.PAC_V !== 1'b1 && cyc < 40) begin
      tick(1);
      cyc++;
    end
    chk("stall_pac_delay", 32'(cyc), 32'd12);
    tick(1);
    m_ptr = 2;

    // Abort at CNT=3, then regrant with pointer unchanged.
    bus.REQ = 4'b0101;
    tick(1);
    chk("abort_gnt", 32'(bus.GNT), 32'(1) << m_ptr);
    tick(9);
    chk("abort_pre_cnt", 32'(bus.CNT), 32'd3);
    bus.PH = 1'b0;
    tick(1);
    chk("abort_gnt_off", 32'(bus.GNT), 32'd0);
    chk("abort_cnt", 32'(bus.CNT), 32'd0);
    chk("abort_led", 32'(bus.LED), 32'd0);
    chk("abort_busy", 32'(bus.BUSY), 32'd0);
    tick(2);
    chk("abort_hold_gnt", 32'(bus.GNT), 32'd0);
    bus.PH = 1'b1;
    tick(1);
    chk("regrant_gnt", 32'(bus.GNT), 32'b0100);
    chk("regrant_cnt", 32'(bus.CNT), 32'd0);
    tick(15);
    chk("regrant_cnt5", 32'(bus.CNT), 32'd5);

    // Reset mid-batch, then pointer must be back at 0.
    reset   = 1'b1;
    bus.REQ = 4'b1001;
    tick(1);
    chk_all_zero("midreset");
    reset = 1'b0;
    exp_q.push_back(2'd0);
    tick(1);
    chk("postreset_gnt", 32'(bus.GNT), 32'b0001);
    bus.REQ = '0;
    tick(BATCH * KNIT_CYC);
    chk("postreset_pack_led", 32'(bus.LED), 32'b100);
    chk("postreset_pack_cnt", 32'(bus.CNT), 32'(BATCH));
    tick(1);
    chk("postreset_idle_led", 32'(bus.LED), 32'd0);
    tick(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound in case a wait goes astray.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
